strobe_timer_bank: RTL

- Bank of CHANNELS independent event counters. Each channel counts its own enable ticks and emits a one-cycle strobe after a programmable number of ticks.
- Each channel runs in periodic (auto-reload) or one-shot mode.
- Channels are configured through a shared valid/ready write port.
- Sits between a control/register block and consumers that need divided-down tick strobes, e.g. baud, sample and timeout generators.

---
 rtl/strobe_timer_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/strobe_timer_bank.sv
// Bank of independent tick-counting timers, each emitting a one-cycle strobe every P ticks.
// Define STROBE_TIMER_IRQ_EN to add sticky per-channel interrupt flags.
module strobe_timer_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  localparam int unsigned CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] tick,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] active
`ifdef STROBE_TIMER_IRQ_EN
  ,
  output logic [CHANNELS-1:0] irq_pending,
  input  logic [CHANNELS-1:0] irq_clear,
  output logic                irq
`endif
);

  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [CHANNELS-1:0] mode_q;
  logic                accept;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] term;

  assign accept = cfg_valid && cfg_ready;

  // Out-of-range channel numbers match no channel, so such writes are accepted and dropped.
  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_hit[n] = accept && (cfg_chan == CHAN_W'(n));
      term[n]   = active[n] && tick[n] && !wr_hit[n] &&
                  (count_q[n] == period_q[n] - WIDTH'(1));
    end
  end

  // A write to a channel overrides any tick on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      strobe    <= '0;
      active    <= '0;
      mode_q    <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        count_q[n]  <= '0;
        period_q[n] <= '0;
      end
    end else begin
      cfg_ready <= !accept;
      strobe    <= term;
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr_hit[n]) begin
          period_q[n] <= cfg_period;
          mode_q[n]   <= cfg_mode;
          count_q[n]  <= '0;
          active[n]   <= (cfg_period != '0);
        end else if (term[n]) begin
          count_q[n] <= '0;
          if (mode_q[n]) active[n] <= 1'b0;
        end else if (active[n] && tick[n]) begin
          count_q[n] <= count_q[n] + WIDTH'(1);
        end
      end
    end
  end

`ifdef STROBE_TIMER_IRQ_EN
  // Sticky flags: a new strobe beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) irq_pending <= '0;
    else     irq_pending <= (irq_pending & ~irq_clear) | term;
  end

  assign irq = |irq_pending;
`endif

endmodule
